// File: rtl/ft2232h_tx_ctrl_pkg.sv
// ft2232h_tx_ctrl_pkg
// Shared definitions for the FT2232H synchronous-245 write controller:
//   - LO / HI pin levels (WR#, TXE#, SIWU# are all active low)
//   - serializer state encoding IDLE / LOAD / SEND
//   - pick_byte(): selects the byte sent at a given position of a word
package ft2232h_tx_ctrl_pkg;

    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_e;

    // Byte sent at position pos (0 = first on the wire) of an nbytes-wide word.
    // With msb_first the lanes are walked from the top of the word downwards.
    function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                             input logic [1:0]  pos,
                                             input logic [2:0]  nbytes,
                                             input logic        msb_first);
        logic [2:0]  lane;
        logic [31:0] shifted;
        if (msb_first) begin
            lane = nbytes - 3'd1 - {1'b0, pos};
        end else begin
            lane = {1'b0, pos};
        end
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/ft_sync_fifo.sv
// ft_sync_fifo
// Single-clock word buffer for the FT2232H write path. Head word is visible
// on pop_data_o whenever the buffer is non-empty (show-ahead), so the
// consumer can capture it on the same edge it pops.
// Ports:
//   clkout_i       sole clock
//   rst_i          synchronous active-high reset (empties the buffer)
//   push_i         write request, taken only while ready_o = 1
//   push_data_i    word to store
//   pop_i          read request, ignored while empty
//   pop_data_o     head word
//   empty_o        buffer holds no word
//   ready_o        buffer can take a word; forced low while rst_i is high
//   level_o        words buffered (registered)
//   level_next_o   level after the coming edge, for callers registering flags
module ft_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clkout_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       empty_o,
    output logic                       ready_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [$clog2(DEPTH):0]     level_next_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic [AW:0]      level_r;
    logic [AW:0]      level_nxt_s;
    logic             ready_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o      = (wr_ptr_r == rd_ptr_r);
    assign ready_o      = ready_r & ~rst_i;
    assign push_ok_s    = push_i & ready_o;
    assign pop_ok_s     = pop_i & ~empty_o;
    assign pop_data_o   = mem_r[rd_ptr_r[AW-1:0]];
    assign level_o      = level_r;
    assign level_next_o = level_nxt_s;

    // Next pointer values and the level/ready they imply.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointer, level and ready registers.
    always_ff @(posedge clkout_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            ready_r  <= (level_nxt_s < DEPTH_L);
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clkout_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ft2232h_tx_ctrl.sv
// ft2232h_tx_ctrl
// FPGA-side write controller for the FT2232H synchronous 245 FIFO. Words
// arrive on a valid/ready handshake, are buffered in ft_sync_fifo, then
// serialized onto ADBUS with the active-low WR# strobe, honouring TXE#.
// A byte is transferred on every edge where TXE# = 0 and WR# = 0.
// Optional build macro FT_SIWU_EN adds siwu_o: a one-clock low pulse after
// FLUSH_CYCLES idle clocks following traffic, so the device sends its
// short packet without waiting for its latency timer.
// Ports:
//   clkout_i      60 MHz CLKOUT from the FT2232H, sole clock
//   rst_i         synchronous active-high reset
//   in_data_i     word to transmit        in_valid_i   word valid
//   in_ready_o    buffer not full
//   txe_i         TXE#, 0 = device can take a byte
//   wr_o          WR#, registered         data_o       ADBUS byte, registered
//   data_oe_o     controller owns the bus fifo_level_o words buffered
//   siwu_o        SIWU#, only with FT_SIWU_EN
//   busy_o        buffer non-empty or a word in flight
module ft2232h_tx_ctrl
    import ft2232h_tx_ctrl_pkg::*;
#(
    parameter int WORD_BYTES   = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter bit MSB_FIRST    = 1'b0,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                          clkout_i,
    input  logic                          rst_i,
    input  logic [8*WORD_BYTES-1:0]       in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          txe_i,
    output logic                          wr_o,
    output logic [7:0]                    data_o,
    output logic                          data_oe_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
`ifdef FT_SIWU_EN
    output logic                          siwu_o,
`endif
    output logic                          busy_o
);

    localparam int         WW       = 8 * WORD_BYTES;
    localparam int         LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);
    localparam logic [2:0] NBYTES   = 3'(WORD_BYTES);

    function automatic logic [31:0] widen(input logic [WW-1:0] w);
        logic [31:0] r;
        r = 32'd0;
        r[WW-1:0] = w;
        return r;
    endfunction

    tx_state_e       state_r;
    tx_state_e       state_nxt_s;
    logic [WW-1:0]   shift_r;
    logic [WW-1:0]   shift_nxt_s;
    logic [1:0]      idx_r;
    logic [1:0]      idx_nxt_s;
    logic            wr_r;
    logic            wr_nxt_s;
    logic [7:0]      data_r;
    logic [7:0]      data_nxt_s;
    logic            oe_r;
    logic            oe_nxt_s;
    logic            busy_r;
    logic            busy_nxt_s;

    logic            pop_s;
    logic [WW-1:0]   fifo_data_s;
    logic            fifo_empty_s;
    logic [LW-1:0]   fifo_level_nxt_s;
    logic            xfer_s;
    logic            last_s;

    ft_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkout_i     (clkout_i),
        .rst_i        (rst_i),
        .push_i       (in_valid_i),
        .push_data_i  (in_data_i),
        .pop_i        (pop_s),
        .pop_data_o   (fifo_data_s),
        .empty_o      (fifo_empty_s),
        .ready_o      (in_ready_o),
        .level_o      (fifo_level_o),
        .level_next_o (fifo_level_nxt_s)
    );

    // WR# is only low in SEND, so this is exactly the device's byte-accept edge.
    assign xfer_s    = (txe_i == LO) && (wr_r == LO);
    assign last_s    = (idx_r == LAST_IDX);
    assign wr_o      = wr_r;
    assign data_o    = data_r;
    assign data_oe_o = oe_r;
    assign busy_o    = busy_r;

    // State register and registered datapath/outputs.
    always_ff @(posedge clkout_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            shift_r <= '0;
            idx_r   <= 2'd0;
            wr_r    <= HI;
            data_r  <= 8'h00;
            oe_r    <= LO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            idx_r   <= idx_nxt_s;
            wr_r    <= wr_nxt_s;
            data_r  <= data_nxt_s;
            oe_r    <= oe_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (txe_i == LO) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            SEND: begin
                if (!xfer_s) begin
                    // Device stalled: drop WR# and re-arm from LOAD.
                    state_nxt_s = LOAD;
                end else if (last_s && fifo_empty_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of pop, shift register, byte index and the pin registers.
    always_comb begin
        pop_s       = 1'b0;
        shift_nxt_s = shift_r;
        idx_nxt_s   = idx_r;
        wr_nxt_s    = HI;
        data_nxt_s  = data_r;
        oe_nxt_s    = oe_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_data_s;
                    idx_nxt_s   = 2'd0;
                    data_nxt_s  = pick_byte(widen(fifo_data_s), 2'd0, NBYTES, MSB_FIRST);
                    oe_nxt_s    = HI;
                end else begin
                    oe_nxt_s    = LO;
                end
            end
            LOAD: begin
                oe_nxt_s = HI;
                if (txe_i == LO) begin
                    wr_nxt_s = LO;
                end else begin
                    wr_nxt_s = HI;
                end
            end
            SEND: begin
                if (!xfer_s) begin
                    // Current byte and index are held for the retry.
                    wr_nxt_s = HI;
                end else if (!last_s) begin
                    idx_nxt_s  = idx_r + 2'd1;
                    data_nxt_s = pick_byte(widen(shift_r), idx_r + 2'd1, NBYTES, MSB_FIRST);
                    wr_nxt_s   = LO;
                end else if (!fifo_empty_s) begin
                    // Chain straight into the next word: no WR# bubble.
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_data_s;
                    idx_nxt_s   = 2'd0;
                    data_nxt_s  = pick_byte(widen(fifo_data_s), 2'd0, NBYTES, MSB_FIRST);
                    wr_nxt_s    = LO;
                end else begin
                    wr_nxt_s = HI;
                    oe_nxt_s = LO;
                end
            end
            default: begin
                wr_nxt_s = HI;
                oe_nxt_s = LO;
            end
        endcase
        busy_nxt_s = (fifo_level_nxt_s != '0) || (state_nxt_s != IDLE);
    end

`ifdef FT_SIWU_EN
    localparam int            CW       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            siwu_r;
    logic            armed_r;
    logic [CW-1:0]   idle_cnt_r;
    logic            accept_s;

    assign accept_s = in_valid_i & in_ready_o;
    assign siwu_o   = siwu_r;

    // Idle counter: arms on a transferred byte, pulses SIWU# once after
    // FLUSH_CYCLES consecutive non-busy clocks, then waits for new traffic.
    always_ff @(posedge clkout_i) begin
        if (rst_i) begin
            siwu_r     <= HI;
            armed_r    <= 1'b0;
            idle_cnt_r <= '0;
        end else begin
            siwu_r <= HI;
            if (xfer_s) begin
                armed_r <= 1'b1;
            end
            if (accept_s || busy_r) begin
                idle_cnt_r <= '0;
            end else if (armed_r && (idle_cnt_r == CNT_LAST)) begin
                siwu_r     <= LO;
                armed_r    <= 1'b0;
                idle_cnt_r <= '0;
            end else if (armed_r) begin
                idle_cnt_r <= idle_cnt_r + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ft2232h_tx_ctrl.sv
module tb_ft2232h_tx_ctrl;

    localparam int WB    = 2;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam bit MSBF  = 1'b0;
    localparam int FLUSH = 64;

    logic            clkout_i = 1'b0;
    logic            rst_i;
    logic [15:0]     in_data_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic            txe_i;
    logic            wr_o;
    logic [7:0]      data_o;
    logic            data_oe_o;
    logic [LW-1:0]   fifo_level_o;
    logic            busy_o;
`ifdef FT_SIWU_EN
    logic            siwu_o;
`endif

    ft2232h_tx_ctrl #(
        .WORD_BYTES   (WB),
        .FIFO_DEPTH   (DEPTH),
        .MSB_FIRST    (MSBF),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clkout_i     (clkout_i),
        .rst_i        (rst_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .txe_i        (txe_i),
        .wr_o         (wr_o),
        .data_o       (data_o),
        .data_oe_o    (data_oe_o),
        .fifo_level_o (fifo_level_o),
`ifdef FT_SIWU_EN
        .siwu_o       (siwu_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clkout_i = ~clkout_i;

    // Model state: bytes still owed to the device, in wire order.
    logic [7:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;
    int n_xfer = 0;
    int first_xfer = -1;
    int last_xfer = -1;

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic        txe;
        logic        chk_d;
        logic        exp_wr;
        logic [7:0]  exp_d;
        logic        exp_oe;
        logic        exp_busy;
        logic [4:0]  exp_lvl;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One clock: note what the device will see at the edge, then update the model.
    task automatic tick();
        logic        do_xfer;
        logic        do_acc;
        logic [7:0]  seen;
        logic        oe_seen;
        logic [15:0] word;
        int          pend;
        int          exp_lvl;
        do_xfer = !rst_i && !txe_i && !wr_o;
        do_acc  = !rst_i && in_valid_i && in_ready_o;
        seen    = data_o;
        oe_seen = data_oe_o;
        word    = in_data_i;
        @(posedge clkout_i);
        #1;
        edge_no++;
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (do_xfer) begin
                n_xfer++;
                if (first_xfer < 0) first_xfer = edge_no;
                last_xfer = edge_no;
                chk("oe_on_xfer", 32'(oe_seen), 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_xfer: byte %0h sent, required nothing pending", seen);
                end else begin
                    chk("xfer_byte", 32'(seen), 32'(exp_q.pop_front()));
                end
            end
            if (do_acc) begin
                for (int k = 0; k < WB; k++) begin
                    int lane;
                    lane = MSBF ? (WB - 1 - k) : k;
                    exp_q.push_back(8'((word >> (8 * lane)) & 16'h00FF));
                end
            end
            chk("busy_vs_pending", 32'(busy_o), 32'(exp_q.size() != 0));
            chk("ready_vs_level", 32'(in_ready_o), 32'(fifo_level_o < DEPTH));
            pend = (exp_q.size() + WB - 1) / WB;
            exp_lvl = (pend > 0 && int'(fifo_level_o) == pend - 1) ? pend - 1 : pend;
            chk("level_vs_pending", 32'(fifo_level_o), 32'(exp_lvl));
            if (!data_oe_o) chk("wr_high_when_bus_free", 32'(wr_o), 32'd1);
        end
    endtask

    task automatic drain();
        int k;
        in_valid_i = 1'b0;
        txe_i = 1'b0;
        k = 0;
        while (k < 300 && (exp_q.size() != 0 || busy_o)) begin
            tick();
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || busy_o) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes pending, busy %0d, required 0 and 0", exp_q.size(), busy_o);
        end
    endtask

    initial begin
        int xb;
        int acc;

        tbl[0]  = '{1'b1, 16'hA55A, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5'd1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 5'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 5'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 5'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0};
        tbl[5]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5'd1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b1, 5'd0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'hEF, 1'b1, 1'b1, 5'd0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'hBE, 1'b1, 1'b1, 5'd0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 5'd0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 5'd0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 5'd0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'hBE, 1'b1, 1'b1, 5'd0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0};

        // Reset state.
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = 16'h0000;
        txe_i = 1'b1;
        tick();
        tick();
        chk("rst_wr", 32'(wr_o), 32'd1);
        chk("rst_data", 32'(data_o), 32'h00);
        chk("rst_oe", 32'(data_oe_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready_o), 32'd1);

        // Cycle-exact vectors: single word A55A, then BEEF with a 3-clock TXE# stall.
        for (int i = 0; i < 14; i++) begin
            in_valid_i = tbl[i].valid;
            in_data_i  = tbl[i].data;
            txe_i      = tbl[i].txe;
            tick();
            chk($sformatf("v%0d_wr", i), 32'(wr_o), 32'(tbl[i].exp_wr));
            if (tbl[i].chk_d) chk($sformatf("v%0d_data", i), 32'(data_o), 32'(tbl[i].exp_d));
            chk($sformatf("v%0d_oe", i), 32'(data_oe_o), 32'(tbl[i].exp_oe));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].exp_busy));
            chk($sformatf("v%0d_level", i), 32'(fifo_level_o), 32'(tbl[i].exp_lvl));
        end
        chk("table_xfers", 32'(n_xfer), 32'd4);

        // Streaming: 8 words back to back must give 16 transfers on 16 consecutive clocks.
        xb = n_xfer;
        first_xfer = -1;
        for (int w = 0; w < 8; w++) begin
            in_valid_i = 1'b1;
            in_data_i  = 16'h0100 + 16'(w);
            txe_i      = 1'b0;
            tick();
        end
        drain();
        chk("stream_count", 32'(n_xfer - xb), 32'd16);
        chk("stream_span", 32'(last_xfer - first_xfer), 32'd15);

        // Fill with TXE# high: one word parks in the serializer, DEPTH more fill the buffer.
        txe_i = 1'b1;
        in_valid_i = 1'b1;
        acc = 0;
        while (acc < 40 && in_ready_o) begin
            in_data_i = 16'($urandom);
            tick();
            acc++;
        end
        chk("fill_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("fill_level", 32'(fifo_level_o), 32'(DEPTH));
        chk("fill_ready", 32'(in_ready_o), 32'd0);
        in_data_i = 16'hDEAD;
        tick();
        chk("full_push_ignored", 32'(fifo_level_o), 32'(DEPTH));
        xb = n_xfer;
        drain();
        chk("fill_drain_bytes", 32'(n_xfer - xb), 32'(2 * (DEPTH + 1)));

        // Reset mid-word: partial word and buffered word are discarded.
        txe_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = 16'h1234;
        tick();
        in_data_i = 16'h5678;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_wr", 32'(wr_o), 32'd1);
        chk("midrst_oe", 32'(data_oe_o), 32'd0);
        chk("midrst_level", 32'(fifo_level_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        xb = n_xfer;
        repeat (6) tick();
        chk("no_xfer_after_rst", 32'(n_xfer - xb), 32'd0);

        // Randomized traffic against the byte-queue model.
        for (int c = 0; c < 3000; c++) begin
            in_valid_i = ($urandom_range(2) != 0);
            in_data_i  = 16'($urandom);
            txe_i      = ($urandom_range(3) == 0);
            tick();
        end
        drain();

`ifdef FT_SIWU_EN
        begin
            int cnt;
            in_valid_i = 1'b1;
            in_data_i = 16'hC0DE;
            tick();
            drain();
            cnt = 0;
            while (cnt < 200 && siwu_o) begin
                tick();
                cnt++;
            end
            chk("siwu_delay", 32'(cnt), 32'(FLUSH));
            tick();
            chk("siwu_width", 32'(siwu_o), 32'd1);
            cnt = 0;
            repeat (150) begin
                tick();
                if (!siwu_o) cnt++;
            end
            chk("siwu_no_repeat", 32'(cnt), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
